// File: rtl/motor_step_bank_pkg.sv
// Shared definitions for the multi-axis step generator: channel state
// encoding and the default widths of the timing and missed-step counters.
package motor_step_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_PULSE = 2'd2,
    ST_POST  = 2'd3
  } chan_state_e;

  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_MISS_W = 8;

endpackage

// File: rtl/motor_step_chan.sv
// Single step channel: endstop synchroniser and gating, the pre/pulse/post
// sequencer, the sticky endstop flag and a saturating missed-step counter.
module motor_step_chan
  import motor_step_bank_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned MISS_W = DEF_MISS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  pre_n_i,
  input  logic [CNT_W-1:0]  pulse_n_i,
  input  logic [CNT_W-1:0]  post_n_i,
  input  logic              step_stb_i,
  input  logic              step_dir_i,
  input  logic              dir_invert_i,
  input  logic              axis_en_i,
  input  logic              endstop_i,
  input  logic              endstop_mask_i,
  input  logic              endstop_dir_i,
  input  logic              clear_flags_i,
  output logic              step_o,
  output logic              dir_o,
  output logic              mot_enable_n_o,
  output logic              busy_o,
  output logic [MISS_W-1:0] missed_cnt_o,
  output logic              endstop_hit_o,
  output logic              block_o
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  chan_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              stepQ_q;
  logic              dirQ_q;
  logic              block_q;
  logic [1:0]        esSync_q;
  logic [MISS_W-1:0] missedCnt_q;
  logic              endstopHit_q;
  logic              motEnN_q;

  logic              blocked;
  logic              isIdle;
  logic [CNT_W-1:0]  pulseLoad;

  // A step moving toward an active, synchronised endstop is refused.
  assign blocked   = endstop_mask_i & esSync_q[1] & (step_dir_i == endstop_dir_i);
  assign isIdle    = (state_q == ST_IDLE);
  // A zero pulse length still produces a one-cycle pulse.
  assign pulseLoad = (pulse_n_i == '0) ? '0 : (pulse_n_i - CNT_ONE);

  // Two-flop synchroniser for the raw asynchronous endstop input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) esSync_q <= 2'b00;
    else        esSync_q <= {esSync_q[0], endstop_i};
  end

  // Driver enable pin follows the enable input one cycle later, inverted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) motEnN_q <= 1'b1;
    else        motEnN_q <= ~axis_en_i;
  end

  // Step sequencer; step, dir and the block pulse are registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stepQ_q <= 1'b0;
      dirQ_q  <= 1'b0;
      block_q <= 1'b0;
    end else begin
      block_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (step_stb_i) begin
            if (blocked) begin
              block_q <= 1'b1;
            end else if (axis_en_i) begin
              dirQ_q <= step_dir_i ^ dir_invert_i;
              if (pre_n_i == '0) begin
                state_q <= ST_PULSE;
                cnt_q   <= pulseLoad;
                stepQ_q <= 1'b1;
              end else begin
                state_q <= ST_PRE;
                cnt_q   <= pre_n_i - CNT_ONE;
              end
            end
          end
        end
        ST_PRE: begin
          if (cnt_q == '0) begin
            state_q <= ST_PULSE;
            cnt_q   <= pulseLoad;
            stepQ_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            stepQ_q <= 1'b0;
            if (post_n_i != '0) begin
              state_q <= ST_POST;
              cnt_q   <= post_n_i - CNT_ONE;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_POST: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
        default: begin
          state_q <= ST_IDLE;
          stepQ_q <= 1'b0;
        end
      endcase
    end
  end

  // Missed-step counter and sticky endstop flag; clearing beats setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missedCnt_q  <= '0;
      endstopHit_q <= 1'b0;
    end else if (clear_flags_i) begin
      missedCnt_q  <= '0;
      endstopHit_q <= 1'b0;
    end else begin
      if (step_stb_i && axis_en_i && !isIdle && (missedCnt_q != '1))
        missedCnt_q <= missedCnt_q + MISS_ONE;
      if (step_stb_i && isIdle && blocked)
        endstopHit_q <= 1'b1;
    end
  end

  assign step_o         = stepQ_q;
  assign dir_o          = dirQ_q;
  assign mot_enable_n_o = motEnN_q;
  assign busy_o         = !isIdle;
  assign missed_cnt_o   = missedCnt_q;
  assign endstop_hit_o  = endstopHit_q;
  assign block_o        = block_q;

endmodule

// File: rtl/motor_step_bank.sv
// Multi-axis step/dir generator: one channel per axis sharing the timing
// settings, with the per-channel endstop block pulses merged into abort.
module motor_step_bank
  import motor_step_bank_pkg::*;
#(
  parameter int unsigned AXES   = 4,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned MISS_W = DEF_MISS_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       pre_n,
  input  logic [CNT_W-1:0]       pulse_n,
  input  logic [CNT_W-1:0]       post_n,
  input  logic [AXES-1:0]        step_stb,
  input  logic [AXES-1:0]        step_dir,
  input  logic [AXES-1:0]        dir_invert,
  input  logic [AXES-1:0]        axis_en,
  input  logic [AXES-1:0]        endstop,
  input  logic [AXES-1:0]        endstop_mask,
  input  logic [AXES-1:0]        endstop_dir,
  input  logic                   clear_flags,
  output logic [AXES-1:0]        step,
  output logic [AXES-1:0]        dir,
  output logic [AXES-1:0]        mot_enable_n,
  output logic [AXES-1:0]        busy,
  output logic [AXES*MISS_W-1:0] missed_cnt,
  output logic [AXES-1:0]        endstop_hit,
  output logic                   abort
);

  logic [AXES-1:0] chanBlock;

  for (genvar k = 0; k < AXES; k++) begin : g_chan
    motor_step_chan #(
      .CNT_W  (CNT_W),
      .MISS_W (MISS_W)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .pre_n_i        (pre_n),
      .pulse_n_i      (pulse_n),
      .post_n_i       (post_n),
      .step_stb_i     (step_stb[k]),
      .step_dir_i     (step_dir[k]),
      .dir_invert_i   (dir_invert[k]),
      .axis_en_i      (axis_en[k]),
      .endstop_i      (endstop[k]),
      .endstop_mask_i (endstop_mask[k]),
      .endstop_dir_i  (endstop_dir[k]),
      .clear_flags_i  (clear_flags),
      .step_o         (step[k]),
      .dir_o          (dir[k]),
      .mot_enable_n_o (mot_enable_n[k]),
      .busy_o         (busy[k]),
      .missed_cnt_o   (missed_cnt[k*MISS_W +: MISS_W]),
      .endstop_hit_o  (endstop_hit[k]),
      .block_o        (chanBlock[k])
    );
  end

  assign abort = |chanBlock;

endmodule

// File: tb/tb_motor_step_bank.sv
// Randomised and directed bench for motor_step_bank, compared cycle by cycle
// against a timeline model: each accepted strobe becomes a step window and a
// busy-until time computed directly from the pre/pulse/post arithmetic.
module tb_motor_step_bank;

  localparam int AXES   = 4;
  localparam int CNT_W  = 16;
  localparam int MISS_W = 8;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [CNT_W-1:0]       pre_n = '0;
  logic [CNT_W-1:0]       pulse_n = '0;
  logic [CNT_W-1:0]       post_n = '0;
  logic [AXES-1:0]        step_stb = '0;
  logic [AXES-1:0]        step_dir = '0;
  logic [AXES-1:0]        dir_invert = '0;
  logic [AXES-1:0]        axis_en = '0;
  logic [AXES-1:0]        endstop = '0;
  logic [AXES-1:0]        endstop_mask = '0;
  logic [AXES-1:0]        endstop_dir = '0;
  logic                   clear_flags = 1'b0;
  logic [AXES-1:0]        step;
  logic [AXES-1:0]        dir;
  logic [AXES-1:0]        mot_enable_n;
  logic [AXES-1:0]        busy;
  logic [AXES*MISS_W-1:0] missed_cnt;
  logic [AXES-1:0]        endstop_hit;
  logic                   abort;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model state, all expressed as absolute cycle numbers.
  longint cyc = 0;
  longint nextFree [AXES];
  longint stepStart[AXES];
  longint stepEnd  [AXES];
  longint abortAt;
  int     missedM  [AXES];
  bit     hitM     [AXES];
  bit     dirM     [AXES];
  bit     prevEn   [AXES];
  bit     esP1     [AXES];
  bit     esP2     [AXES];

  motor_step_bank #(
    .AXES   (AXES),
    .CNT_W  (CNT_W),
    .MISS_W (MISS_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pre_n        (pre_n),
    .pulse_n      (pulse_n),
    .post_n       (post_n),
    .step_stb     (step_stb),
    .step_dir     (step_dir),
    .dir_invert   (dir_invert),
    .axis_en      (axis_en),
    .endstop      (endstop),
    .endstop_mask (endstop_mask),
    .endstop_dir  (endstop_dir),
    .clear_flags  (clear_flags),
    .step         (step),
    .dir          (dir),
    .mot_enable_n (mot_enable_n),
    .busy         (busy),
    .missed_cnt   (missed_cnt),
    .endstop_hit  (endstop_hit),
    .abort        (abort)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < AXES; k++) begin
      nextFree[k]  = 0;
      stepStart[k] = 1;
      stepEnd[k]   = 0;
      missedM[k]   = 0;
      hitM[k]      = 1'b0;
      dirM[k]      = 1'b0;
      prevEn[k]    = 1'b0;
      esP1[k]      = 1'b0;
      esP2[k]      = 1'b0;
    end
    abortAt = -1;
  endtask

  function automatic bit allIdle();
    for (int k = 0; k < AXES; k++)
      if (cyc < nextFree[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkAll();
    for (int k = 0; k < AXES; k++) begin
      bit expStep;
      expStep = (cyc >= stepStart[k]) && (cyc <= stepEnd[k]);
      checkOutput($sformatf("step%0d", k), 32'(step[k]), 32'(expStep));
      checkOutput($sformatf("dir%0d", k), 32'(dir[k]), 32'(dirM[k]));
      checkOutput($sformatf("busy%0d", k), 32'(busy[k]), 32'(cyc < nextFree[k]));
      checkOutput($sformatf("enN%0d", k), 32'(mot_enable_n[k]), 32'(!prevEn[k]));
      checkOutput($sformatf("missed%0d", k), 32'(missed_cnt[k*MISS_W +: MISS_W]),
                  32'(missedM[k]));
      checkOutput($sformatf("hit%0d", k), 32'(endstop_hit[k]), 32'(hitM[k]));
    end
    checkOutput("abort", 32'(abort), 32'(abortAt == cyc));
  endtask

  // Drive one cycle of inputs, advance the model past the next edge, check.
  task automatic applyStimulus(input logic [AXES-1:0] stb, input logic [AXES-1:0] dv,
                               input logic [AXES-1:0] inv, input logic [AXES-1:0] en,
                               input logic [AXES-1:0] mask, input logic [AXES-1:0] esd,
                               input logic clr);
    bit anyBlock;
    step_stb = stb; step_dir = dv; dir_invert = inv; axis_en = en;
    endstop_mask = mask; endstop_dir = esd; clear_flags = clr;
    anyBlock = 1'b0;
    for (int k = 0; k < AXES; k++) begin
      bit busyNow, blk;
      int plen;
      busyNow = cyc < nextFree[k];
      blk = mask[k] && esP2[k] && (dv[k] == esd[k]);
      if (clr) begin
        missedM[k] = 0;
        hitM[k] = 1'b0;
      end
      if (stb[k]) begin
        if (busyNow) begin
          if (en[k] && !clr && missedM[k] < MISS_MAX) missedM[k]++;
        end else if (blk) begin
          if (!clr) hitM[k] = 1'b1;
          anyBlock = 1'b1;
        end else if (en[k]) begin
          plen = (int'(pulse_n) == 0) ? 1 : int'(pulse_n);
          dirM[k]      = dv[k] ^ inv[k];
          stepStart[k] = cyc + longint'(pre_n) + 1;
          stepEnd[k]   = cyc + longint'(pre_n) + plen;
          nextFree[k]  = cyc + longint'(pre_n) + plen + longint'(post_n) + 1;
        end
      end
      prevEn[k] = en[k];
      esP2[k] = esP1[k];
      esP1[k] = endstop[k];
    end
    if (anyBlock) abortAt = cyc + 1;
    @(posedge clk);
    #1;
    cyc++;
    checkAll();
  endtask

  // Run quiet cycles (enables kept on) until the model says every axis is idle.
  task automatic waitIdle(input logic [AXES-1:0] en);
    for (int i = 0; i < 5000 && !allIdle(); i++)
      applyStimulus('0, '0, '0, en, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, en, '0, '0, 1'b0);
  endtask

  task automatic setTiming(input int pr, input int pu, input int po);
    pre_n = CNT_W'(pr); pulse_n = CNT_W'(pu); post_n = CNT_W'(po);
  endtask

  initial begin
    logic [AXES-1:0] rs, rd, ri, re, rm, red;
    logic rc;

    // Reset state.
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_step", 32'(step), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_dir", 32'(dir), 32'(0));
    checkOutput("rst_enN", 32'(mot_enable_n), 32'hF);
    checkOutput("rst_missed", missed_cnt, 32'(0));
    checkOutput("rst_hit", 32'(endstop_hit), 32'(0));
    checkOutput("rst_abort", 32'(abort), 32'(0));
    rst_n = 1'b1;

    // pre=2 pulse=3 post=1 on axis 0.
    setTiming(2, 3, 1);
    applyStimulus('0, '0, '0, 4'hF, '0, '0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, '0, 4'hF, '0, '0, 1'b0);
    waitIdle(4'hF);

    // Zero timing: one-cycle pulses, strobes every second cycle all accepted.
    setTiming(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0001, 4'(i), '0, 4'hF, '0, '0, 1'b0);
      applyStimulus('0, '0, '0, 4'hF, '0, '0, 1'b0);
    end
    checkOutput("b2b_missed0", 32'(missed_cnt[MISS_W-1:0]), 32'(0));

    // Long pulse on axis 1 with strobes at relative cycles 0, 3, 5.
    setTiming(0, 10, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus((i == 0 || i == 3 || i == 5) ? 4'b0010 : 4'b0000, '0, '0, 4'hF, '0, '0, 1'b0);
    checkOutput("miss1_two", 32'(missed_cnt[2*MISS_W-1:MISS_W]), 32'(2));
    waitIdle(4'hF);

    // Saturation: one long step and 300 strobes while busy, then clear.
    setTiming(0, 400, 0);
    applyStimulus(4'b0010, '0, '0, 4'hF, '0, '0, 1'b0);
    for (int i = 0; i < 300; i++)
      applyStimulus(4'b0010, '0, '0, 4'hF, '0, '0, 1'b0);
    checkOutput("miss1_sat", 32'(missed_cnt[2*MISS_W-1:MISS_W]), 32'(MISS_MAX));
    applyStimulus('0, '0, '0, 4'hF, '0, '0, 1'b1);
    checkOutput("miss1_clr", 32'(missed_cnt[2*MISS_W-1:MISS_W]), 32'(0));
    waitIdle(4'hF);

    // Endstop on axis 2: blocked toward it, allowed away from it.
    setTiming(1, 2, 1);
    endstop = 4'b0100;
    repeat (3) applyStimulus('0, '0, '0, 4'hF, 4'b0100, 4'b0100, 1'b0);
    applyStimulus(4'b0100, 4'b0100, '0, 4'hF, 4'b0100, 4'b0100, 1'b0);
    checkOutput("es_abort", 32'(abort), 32'(1));
    checkOutput("es_hit2", 32'(endstop_hit[2]), 32'(1));
    applyStimulus('0, '0, '0, 4'hF, 4'b0100, 4'b0100, 1'b0);
    checkOutput("es_abort_once", 32'(abort), 32'(0));
    applyStimulus(4'b0100, 4'b0000, '0, 4'hF, 4'b0100, 4'b0100, 1'b0);
    checkOutput("es_away_busy", 32'(busy[2]), 32'(1));
    waitIdle(4'hF);
    endstop = '0;

    // Direction inversion on two axes stepping together.
    setTiming(0, 1, 0);
    applyStimulus(4'b0011, 4'b0011, 4'b1010, 4'hF, '0, '0, 1'b0);
    checkOutput("inv_dir", 32'(dir[1:0]), 32'(2'b01));
    checkOutput("inv_step", 32'(step[1:0]), 32'(2'b11));
    waitIdle(4'hF);

    // Reset in the middle of a pulse, then a full sequence afterwards.
    setTiming(1, 5, 2);
    applyStimulus(4'b0001, 4'b0001, '0, 4'hF, '0, '0, 1'b0);
    repeat (3) applyStimulus('0, '0, '0, 4'hF, '0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_step", 32'(step), 32'(0));
    checkOutput("mid_rst_busy", 32'(busy), 32'(0));
    checkOutput("mid_rst_dir", 32'(dir), 32'(0));
    checkOutput("mid_rst_enN", 32'(mot_enable_n), 32'hF);
    step_stb = '0; axis_en = '0; clear_flags = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus('0, '0, '0, 4'hF, '0, '0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, '0, 4'hF, '0, '0, 1'b0);
    waitIdle(4'hF);

    // Randomised segments: timing and endstops change only while idle.
    for (int seg = 0; seg < 30; seg++) begin
      setTiming(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)));
      endstop = 4'($urandom_range(0, 15));
      for (int i = 0; i < 40; i++) begin
        for (int k = 0; k < AXES; k++) begin
          rs[k] = ($urandom_range(0, 2) == 0);
          re[k] = ($urandom_range(0, 4) != 0);
        end
        rd  = 4'($urandom_range(0, 15));
        ri  = 4'($urandom_range(0, 15));
        rm  = 4'($urandom_range(0, 15));
        red = 4'($urandom_range(0, 15));
        rc  = ($urandom_range(0, 15) == 0);
        applyStimulus(rs, rd, ri, re, rm, red, rc);
      end
      waitIdle(4'hF);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
